// File: rtl/fadd_accum_seq.sv
// fadd_accum_seq: sequences a float stream through an external fadd, one add per element, and presents the sum.
// Optional FADD_ACC_ZERO_SKIP_EN counts zero-valued non-first elements without issuing them to fadd.
module fadd_accum_seq #(
  parameter int N        = 32,
  parameter int E        = 8,
  parameter int S        = 1,
  parameter int FADD_LAT = 3,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          fadd_en,
  output logic [N-1:0]  fadd_op1,
  output logic [N-1:0]  fadd_op2,
  input  logic          fadd_res_val,
  input  logic [N-1:0]  fadd_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_err
);
  localparam int WW = $clog2(FADD_LAT + 3);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
`ifdef FADD_ACC_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d, op1_q, op1_d, op2_q, op2_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d, last_q, last_d, zero_el;
  assign zero_el   = (in_data[N-S-1 -: E] == '0) && (in_data[N-S-E-1:0] == '0);
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign in_ready  = state_q == IDLE;
  assign fadd_en   = state_q == ISSUE;
  assign out_valid = state_q == DONE;
  assign fadd_op1  = op1_q;
  assign fadd_op2  = op2_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_err   = err_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q || (fadd_res_val && state_q != WAIT);
    op1_d   = op1_q;
    op2_d   = op2_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (cnt_q == '0) begin
          acc_d   = in_data;
          cnt_d   = CW'(1);
          state_d = in_last ? DONE : IDLE;
        end else if (ZSKIP && zero_el) begin
          cnt_d   = cnt_inc;
          state_d = in_last ? DONE : IDLE;
        end else begin
          op1_d   = acc_q;
          op2_d   = in_data;
          last_d  = in_last;
          cnt_d   = cnt_inc;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A missing result is flagged and the stream moves on with acc untouched.
        if (fadd_res_val) begin
          acc_d   = fadd_res;
          state_d = last_q ? DONE : IDLE;
        end else if (wdog_q == WW'(FADD_LAT + 2)) begin
          err_d   = 1'b1;
          state_d = last_q ? DONE : IDLE;
        end
      end
      default: if (out_ready) begin
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      last_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end
endmodule
